// File: rtl/memory_arbiter.sv
// Multi-channel memory arbiter: grants one of NUM_CH requesters onto a
// single RAM port (fixed priority or round-robin) and returns a ready pulse.
//
// Ports:
//   clk, nRst            clock, async active-low reset
//   req_ren / req_wen    per-channel read / write request levels
//   req_addr / req_store packed per-channel address / write data
//   req_ready            one-hot completion pulse to the winning channel
//   req_load             last read word, valid with req_ready
//   ram_ren / ram_wen    RAM strobes (exactly one high while BUSY)
//   ram_addr / ram_store latched address / write data
//   ram_load / ram_busy  RAM read data / access-in-progress flag
module memory_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_MODE = 1
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic [NUM_CH-1:0]        req_ren,
    input  logic [NUM_CH-1:0]        req_wen,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_store,
    output logic [NUM_CH-1:0]        req_ready,
    output logic [DATA_W-1:0]        req_load,
    output logic                     ram_ren,
    output logic                     ram_wen,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_store,
    input  logic [DATA_W-1:0]        ram_load,
    input  logic                     ram_busy
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

    logic [1:0]        state;
    logic [IDX_W-1:0]  win;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  pick;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_store;
    logic [DATA_W-1:0] load_q;
    logic              lat_wr;
    logic [NUM_CH-1:0] pending;
    logic              pending_any;

    assign pending     = req_ren | req_wen;
    assign pending_any = |pending;

    // Winner selection. Round-robin walks from last_grant+1 with wrap;
    // fixed priority scans downward so the lowest pending index is kept.
    always_comb begin : arb
        int               c;
        logic [IDX_W-1:0] ci;
        logic             found;
        pick  = '0;
        c     = 0;
        ci    = '0;
        found = 1'b0;
        if (RR_MODE != 0) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                c = int'(last_grant) + k;
                if (c >= NUM_CH)
                    c = c - NUM_CH;
                ci = IDX_W'(c);
                if (!found && pending[ci]) begin
                    pick  = ci;
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                ci = IDX_W'(i);
                if (pending[ci])
                    pick = ci;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            win        <= '0;
            last_grant <= LAST_CH;
            lat_addr   <= '0;
            lat_store  <= '0;
            lat_wr     <= 1'b0;
            load_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending_any) begin
                        win        <= pick;
                        last_grant <= pick;
                        lat_addr   <= req_addr[pick*ADDR_W +: ADDR_W];
                        lat_store  <= req_store[pick*DATA_W +: DATA_W];
                        // Write wins when both strobes are raised.
                        lat_wr     <= req_wen[pick];
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (!ram_busy) begin
                        if (!lat_wr)
                            load_q <= ram_load;
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // All outputs come from registered state only.
    assign ram_ren   = (state == BUSY) && !lat_wr;
    assign ram_wen   = (state == BUSY) && lat_wr;
    assign ram_addr  = lat_addr;
    assign ram_store = lat_store;
    assign req_load  = load_q;

    always_comb begin
        req_ready = '0;
        if (state == RESP)
            req_ready[win] = 1'b1;
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: a 4-channel round-robin and a
// 4-channel fixed-priority instance share stimulus.
module tb_memory_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          nRst;
    logic [N-1:0]  ren, wen;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] store;
    logic [DW-1:0] rload;
    logic          rbusy;

    logic [N-1:0]  o_ready [2];
    logic [DW-1:0] o_load  [2];
    logic          o_ren   [2];
    logic          o_wen   [2];
    logic [AW-1:0] o_addr  [2];
    logic [DW-1:0] o_store [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    memory_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) u_rr (
        .clk(clk), .nRst(nRst),
        .req_ren(ren), .req_wen(wen), .req_addr(addr), .req_store(store),
        .req_ready(o_ready[0]), .req_load(o_load[0]),
        .ram_ren(o_ren[0]), .ram_wen(o_wen[0]),
        .ram_addr(o_addr[0]), .ram_store(o_store[0]),
        .ram_load(rload), .ram_busy(rbusy)
    );

    memory_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) u_fp (
        .clk(clk), .nRst(nRst),
        .req_ren(ren), .req_wen(wen), .req_addr(addr), .req_store(store),
        .req_ready(o_ready[1]), .req_load(o_load[1]),
        .ram_ren(o_ren[1]), .ram_wen(o_wen[1]),
        .ram_addr(o_addr[1]), .ram_store(o_store[1]),
        .ram_load(rload), .ram_busy(rbusy)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic string pn(input int p);
        return (p == 0) ? "rr" : "fp";
    endfunction

    // Transaction-level reference: phase 0 waiting, 1 accessing RAM,
    // 2 reporting completion.
    int            m_ph   [2];
    int            m_ch   [2];
    int            m_last [2];
    logic [31:0]   m_addr [2];
    logic [31:0]   m_data [2];
    logic [31:0]   m_load [2];
    bit            m_wr   [2];

    function automatic int choose(input int p);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (p == 0) ? (m_last[p] + k) % N : k - 1;
            if (ren[c] || wen[c])
                return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_ph[p]   = 0;
            m_ch[p]   = 0;
            m_last[p] = N - 1;
            m_addr[p] = '0;
            m_data[p] = '0;
            m_load[p] = '0;
            m_wr[p]   = 1'b0;
        end
    endtask

    task automatic model_step();
        int c;
        for (int p = 0; p < 2; p++) begin
            if (m_ph[p] == 0) begin
                c = choose(p);
                if (c >= 0) begin
                    m_ch[p]   = c;
                    m_last[p] = c;
                    m_addr[p] = addr[c*AW +: AW];
                    m_data[p] = store[c*DW +: DW];
                    m_wr[p]   = wen[c];
                    m_ph[p]   = 1;
                end
            end else if (m_ph[p] == 1) begin
                if (!rbusy) begin
                    if (!m_wr[p])
                        m_load[p] = rload;
                    m_ph[p] = 2;
                end
            end else begin
                m_ph[p] = 0;
            end
        end
    endtask

    task automatic model_check();
        logic [3:0] er;
        for (int p = 0; p < 2; p++) begin
            er = (m_ph[p] == 2) ? 4'(1 << m_ch[p]) : 4'b0;
            chk({pn(p), " rnd ram_ren"}, 32'(o_ren[p]),
                32'(m_ph[p] == 1 && !m_wr[p]));
            chk({pn(p), " rnd ram_wen"}, 32'(o_wen[p]),
                32'(m_ph[p] == 1 && m_wr[p]));
            if (m_ph[p] == 1) begin
                chk({pn(p), " rnd ram_addr"}, o_addr[p], m_addr[p]);
                chk({pn(p), " rnd ram_store"}, o_store[p], m_data[p]);
            end
            chk({pn(p), " rnd req_ready"}, 32'(o_ready[p]), 32'(er));
            chk({pn(p), " rnd req_load"}, o_load[p], m_load[p]);
        end
    endtask

    task automatic zero_inputs();
        ren   = '0;
        wen   = '0;
        addr  = '0;
        store = '0;
        rload = '0;
        rbusy = 1'b0;
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        zero_inputs();
        repeat (2) @(posedge clk);
        #1;
        nRst = 1'b1;
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i])
                return i;
        return -1;
    endfunction

    typedef struct {
        logic [3:0]  ren;
        logic [3:0]  wen;
        logic [31:0] a;
        logic [31:0] d;
        logic        busy;
        logic [31:0] ld;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
        logic [3:0]  e_rdy;
        logic [31:0] e_load;
    } vec_t;

    vec_t tv [12];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          q [2][$];
        int          exp_rr [5];
        int          exp_fp [5];
        logic [31:0] e_a, e_d;

        tv[0]  = '{4'h1, 4'h0, 32'h40,  32'h0,        1'b0, 32'hDEADBEEF,
                   1'b1, 1'b0, 32'h40,  32'h0,        4'h0, 32'h0};
        tv[1]  = '{4'h1, 4'h0, 32'h40,  32'h0,        1'b0, 32'hDEADBEEF,
                   1'b0, 1'b0, 32'h0,   32'h0,        4'h1, 32'hDEADBEEF};
        tv[2]  = '{4'h0, 4'h0, 32'h0,   32'h0,        1'b1, 32'h0,
                   1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 32'hDEADBEEF};
        tv[3]  = '{4'h0, 4'h2, 32'h100, 32'h12345678, 1'b1, 32'h5555AAAA,
                   1'b0, 1'b1, 32'h100, 32'h12345678, 4'h0, 32'hDEADBEEF};
        tv[4]  = '{4'h0, 4'h2, 32'h999, 32'hFFFFFFFF, 1'b1, 32'h5555AAAA,
                   1'b0, 1'b1, 32'h100, 32'h12345678, 4'h0, 32'hDEADBEEF};
        tv[5]  = tv[4];
        tv[6]  = tv[4];
        tv[7]  = '{4'h0, 4'h2, 32'h100, 32'h12345678, 1'b0, 32'h5555AAAA,
                   1'b0, 1'b0, 32'h0,   32'h0,        4'h2, 32'hDEADBEEF};
        tv[8]  = '{4'h0, 4'h0, 32'h0,   32'h0,        1'b0, 32'h0,
                   1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 32'hDEADBEEF};
        tv[9]  = '{4'h1, 4'h1, 32'h200, 32'hCAFEF00D, 1'b0, 32'h5555AAAA,
                   1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 4'h0, 32'hDEADBEEF};
        tv[10] = '{4'h1, 4'h1, 32'h200, 32'hCAFEF00D, 1'b0, 32'h5555AAAA,
                   1'b0, 1'b0, 32'h0,   32'h0,        4'h1, 32'hDEADBEEF};
        tv[11] = tv[8];

        exp_rr = '{0, 1, 2, 3, 0};
        exp_fp = '{0, 0, 0, 0, 0};

        // Reset with random inputs toggling underneath.
        nRst = 1'b0;
        zero_inputs();
        for (int i = 0; i < 5; i++) begin
            ren   = 4'($urandom);
            wen   = 4'($urandom);
            addr  = {$urandom, $urandom, $urandom, $urandom};
            store = {$urandom, $urandom, $urandom, $urandom};
            rload = $urandom;
            rbusy = 1'($urandom);
            @(posedge clk);
            #1;
        end
        zero_inputs();
        nRst = 1'b1;
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            chk({pn(p), " reset req_ready"}, 32'(o_ready[p]), 32'h0);
            chk({pn(p), " reset req_load"}, o_load[p], 32'h0);
            chk({pn(p), " reset ram_ren"}, 32'(o_ren[p]), 32'h0);
            chk({pn(p), " reset ram_wen"}, 32'(o_wen[p]), 32'h0);
            chk({pn(p), " reset ram_addr"}, o_addr[p], 32'h0);
            chk({pn(p), " reset ram_store"}, o_store[p], 32'h0);
        end

        // All channels requesting continuously: grant order per policy.
        ren = 4'hF;
        for (int c = 0; c < N; c++)
            addr[c*AW +: AW] = 32'h1000 + 32'(c * 4);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++)
                if (o_ready[p] != '0 && q[p].size() < 5)
                    q[p].push_back(oh2idx(o_ready[p]));
            if (q[0].size() >= 5 && q[1].size() >= 5)
                break;
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr grant %0d", i),
                (q[0].size() > i) ? 32'(q[0][i]) : 32'hFFFFFFFF,
                32'(exp_rr[i]));
            chk($sformatf("fp grant %0d", i),
                (q[1].size() > i) ? 32'(q[1][i]) : 32'hFFFFFFFF,
                32'(exp_fp[i]));
        end

        // Directed vectors: min-latency read, stalled write, dual strobe.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            ren   = tv[i].ren;
            wen   = tv[i].wen;
            addr  = {N{tv[i].a}};
            store = {N{tv[i].d}};
            rbusy = tv[i].busy;
            rload = tv[i].ld;
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("%s vec%0d ram_ren", pn(p), i),
                    32'(o_ren[p]), 32'(tv[i].e_ren));
                chk($sformatf("%s vec%0d ram_wen", pn(p), i),
                    32'(o_wen[p]), 32'(tv[i].e_wen));
                if (tv[i].e_ren || tv[i].e_wen) begin
                    e_a = tv[i].e_addr;
                    e_d = tv[i].e_store;
                    chk($sformatf("%s vec%0d ram_addr", pn(p), i),
                        o_addr[p], e_a);
                    chk($sformatf("%s vec%0d ram_store", pn(p), i),
                        o_store[p], e_d);
                end
                chk($sformatf("%s vec%0d req_ready", pn(p), i),
                    32'(o_ready[p]), 32'(tv[i].e_rdy));
                chk($sformatf("%s vec%0d req_load", pn(p), i),
                    o_load[p], tv[i].e_load);
            end
        end

        // Reset in the second BUSY cycle of a stalled read.
        ren   = 4'h1;
        addr  = {N{32'h300}};
        rbusy = 1'b1;
        @(posedge clk);
        #1;
        chk("rr midrst busy1 ram_ren", 32'(o_ren[0]), 32'h1);
        @(posedge clk);
        #1;
        chk("rr midrst busy2 ram_ren", 32'(o_ren[0]), 32'h1);
        #2;
        nRst = 1'b0;
        #1;
        for (int p = 0; p < 2; p++) begin
            chk({pn(p), " midrst async ram_ren"}, 32'(o_ren[p]), 32'h0);
            chk({pn(p), " midrst async ram_wen"}, 32'(o_wen[p]), 32'h0);
            chk({pn(p), " midrst async ready"}, 32'(o_ready[p]), 32'h0);
            chk({pn(p), " midrst async load"}, o_load[p], 32'h0);
        end
        ren = '0;
        @(posedge clk);
        #1;
        nRst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("%s midrst quiet%0d ready", pn(p), i),
                    32'(o_ready[p]), 32'h0);
                chk($sformatf("%s midrst quiet%0d ram_ren", pn(p), i),
                    32'(o_ren[p]), 32'h0);
            end
        end
        ren   = 4'h1;
        rbusy = 1'b0;
        rload = 32'h0BADF00D;
        @(posedge clk);
        #1;
        chk("rr restart ram_ren", 32'(o_ren[0]), 32'h1);
        chk("rr restart ram_addr", o_addr[0], 32'h300);
        @(posedge clk);
        #1;
        chk("rr restart ready", 32'(o_ready[0]), 32'h1);
        chk("rr restart load", o_load[0], 32'h0BADF00D);
        ren = '0;

        // Randomised traffic against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                ren[c] = ($urandom_range(0, 2) == 0);
                wen[c] = ($urandom_range(0, 3) == 0);
            end
            addr  = {$urandom, $urandom, $urandom, $urandom};
            store = {$urandom, $urandom, $urandom, $urandom};
            rload = $urandom;
            rbusy = 1'($urandom_range(0, 1));
            model_step();
            @(posedge clk);
            #1;
            model_check();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
